// File: rtl/io_pinmux_ctrl_if.sv
// AHB-Lite slave bundle for the pad mux register block.
// Latency: wires only; backpressure: slave drives HREADYOUT/HRESP, master feeds HREADY back.
interface io_pinmux_ctrl_if;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [7:0]  HADDR;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HREADY, HWDATA,
                    input  HRDATA, HREADYOUT, HRESP);
    modport slave  (input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HREADY, HWDATA,
                    output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/io_pinmux_ctrl.sv
// Key-protected alt0/alt1 pad owner mux with a tri-state guard after every ownership change.
// Latency: pad path combinational, register updates next edge; backpressure: only the 2-cycle AHB error.
module io_pinmux_ctrl #(
    parameter int NPADS       = 38,
    parameter int GUARD       = 4,
    parameter int KEY_TIMEOUT = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    io_pinmux_ctrl_if.slave  ahb,
    input  logic [NPADS-1:0] alt0_out,
    input  logic [NPADS-1:0] alt0_oeb,
    input  logic [NPADS-1:0] alt1_out,
    input  logic [NPADS-1:0] alt1_oeb,
    input  logic [NPADS-1:0] pad_in,
    output logic [NPADS-1:0] alt0_in,
    output logic [NPADS-1:0] alt1_in,
    output logic [NPADS-1:0] pad_out,
    output logic [NPADS-1:0] pad_oeb
);
    localparam int          HIW        = NPADS - 32;
    localparam logic [31:0] KEY_ARM    = 32'h5A5A_0001;
    localparam logic [31:0] KEY_UNLOCK = 32'hA5A5_0002;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_ARMED    = 2'd1,
        ST_UNLOCKED = 2'd2
    } lock_e;

    lock_e            lock_q, lock_d;
    logic [7:0]       timer_q, timer_d;
    logic [NPADS-1:0] sel_q, sel_d;
    logic [NPADS-1:0] guard_mask_q, guard_mask_d;
    logic [3:0]       guard_cnt_q, guard_cnt_d;
    logic             dph_vld_q, dph_vld_d;
    logic             dph_wr_q, dph_wr_d;
    logic [7:0]       dph_addr_q, dph_addr_d;
    logic [2:0]       dph_size_q, dph_size_d;
    logic             err2_q, err2_d;

    logic             a_sel_lo, a_sel_hi, a_status, a_key;
    logic             bad_access, err1, key_wr, sel_wr;
    logic             unlocked;
    logic [1:0]       lock_code;
    logic [NPADS-1:0] sel_new, changed;
    logic [31:0]      rdata;
    logic             unused_htrans0;

    assign unused_htrans0 = ahb.HTRANS[0];

    // Address phase capture; while HREADY is low only our own error stall is in progress.
    always_comb begin
        dph_vld_d  = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
        dph_wr_d   = dph_wr_q;
        dph_addr_d = dph_addr_q;
        dph_size_d = dph_size_q;
        if (dph_vld_d) begin
            dph_wr_d   = ahb.HWRITE;
            dph_addr_d = ahb.HADDR;
            dph_size_d = ahb.HSIZE;
        end
    end

    always_comb begin
        a_sel_lo   = (dph_addr_q == 8'h00);
        a_sel_hi   = (dph_addr_q == 8'h04);
        a_status   = (dph_addr_q == 8'h08);
        a_key      = (dph_addr_q == 8'h0C);
        bad_access = !(a_sel_lo || a_sel_hi || a_status || a_key)
                   || (dph_size_q != 3'd2)
                   || (dph_wr_q && a_status)
                   || (dph_wr_q && (a_sel_lo || a_sel_hi) && !unlocked);
        key_wr     = dph_vld_q && dph_wr_q && a_key;
        err1       = dph_vld_q && !key_wr && bad_access;
        sel_wr     = dph_vld_q && dph_wr_q && (a_sel_lo || a_sel_hi) && !err1;
        err2_d     = err1;
    end

    // Lock FSM: next-state process.
    always_comb begin
        lock_d  = lock_q;
        timer_d = 8'd0;
        unique case (lock_q)
            ST_LOCKED: begin
                if (key_wr && ahb.HWDATA == KEY_ARM) begin
                    lock_d  = ST_ARMED;
                    timer_d = 8'(KEY_TIMEOUT);
                end
            end
            ST_ARMED: begin
                timer_d = timer_q - 8'd1;
                // A key write landing on the last armed cycle still counts.
                if (key_wr)
                    lock_d = (ahb.HWDATA == KEY_UNLOCK) ? ST_UNLOCKED : ST_LOCKED;
                else if (timer_q == 8'd1)
                    lock_d = ST_LOCKED;
            end
            ST_UNLOCKED: begin
                if (key_wr)
                    lock_d = ST_LOCKED;
            end
            default: lock_d = ST_LOCKED;
        endcase
    end

    // Lock FSM: output process.
    always_comb begin
        lock_code = lock_q;
        unlocked  = (lock_q == ST_UNLOCKED);
    end

    always_comb begin
        sel_new = sel_q;
        if (a_sel_lo)
            sel_new[31:0] = ahb.HWDATA;
        if (a_sel_hi)
            sel_new[NPADS-1:32] = ahb.HWDATA[HIW-1:0];
        changed = sel_new ^ sel_q;

        sel_d        = sel_q;
        guard_mask_d = guard_mask_q;
        guard_cnt_d  = guard_cnt_q;
        if (guard_cnt_q != 4'd0) begin
            guard_cnt_d = guard_cnt_q - 4'd1;
            if (guard_cnt_q == 4'd1)
                guard_mask_d = '0;
        end
        // Applied after expiry so a write on the expiring cycle starts a fresh mask.
        if (sel_wr) begin
            sel_d = sel_new;
            if (changed != '0) begin
                guard_mask_d = guard_mask_d | changed;
                guard_cnt_d  = 4'(GUARD);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (dph_vld_q && !dph_wr_q && !err1) begin
            if (a_sel_lo)
                rdata = sel_q[31:0];
            else if (a_sel_hi)
                rdata = 32'(sel_q >> 32);
            else if (a_status)
                rdata = {29'd0, guard_cnt_q != 4'd0, lock_code};
        end
    end

    assign ahb.HRDATA    = rdata;
    assign ahb.HREADYOUT = !err1;
    assign ahb.HRESP     = err1 || err2_q;

    assign alt1_in = pad_in & sel_q;
    assign alt0_in = pad_in & ~sel_q;
    assign pad_out = ~guard_mask_q & ((sel_q & alt1_out) | (~sel_q & alt0_out));
    assign pad_oeb = guard_mask_q | (sel_q & alt1_oeb) | (~sel_q & alt0_oeb);

    // Lock FSM state register together with the rest of the block state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lock_q       <= ST_LOCKED;
            timer_q      <= 8'd0;
            sel_q        <= '0;
            guard_mask_q <= '0;
            guard_cnt_q  <= 4'd0;
            dph_vld_q    <= 1'b0;
            dph_wr_q     <= 1'b0;
            dph_addr_q   <= 8'd0;
            dph_size_q   <= 3'd0;
            err2_q       <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            timer_q      <= timer_d;
            sel_q        <= sel_d;
            guard_mask_q <= guard_mask_d;
            guard_cnt_q  <= guard_cnt_d;
            dph_vld_q    <= dph_vld_d;
            dph_wr_q     <= dph_wr_d;
            dph_addr_q   <= dph_addr_d;
            dph_size_q   <= dph_size_d;
            err2_q       <= err2_d;
        end
    end
endmodule

// File: tb/tb_io_pinmux_ctrl.sv
// Directed plus random bench for io_pinmux_ctrl against a cycle-stamped reference model.
module tb_io_pinmux_ctrl;
    localparam int          NPADS       = 38;
    localparam int          GUARD       = 4;
    localparam int          KEY_TIMEOUT = 16;
    localparam logic [31:0] K1          = 32'h5A5A_0001;
    localparam logic [31:0] K2          = 32'hA5A5_0002;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic [NPADS-1:0] alt0_out, alt0_oeb, alt1_out, alt1_oeb, pad_in;
    logic [NPADS-1:0] alt0_in, alt1_in, pad_out, pad_oeb;

    io_pinmux_ctrl_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    io_pinmux_ctrl #(.NPADS(NPADS), .GUARD(GUARD), .KEY_TIMEOUT(KEY_TIMEOUT)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .ahb     (bus),
        .alt0_out(alt0_out),
        .alt0_oeb(alt0_oeb),
        .alt1_out(alt1_out),
        .alt1_oeb(alt1_oeb),
        .pad_in  (pad_in),
        .alt0_in (alt0_in),
        .alt1_in (alt1_in),
        .pad_out (pad_out),
        .pad_oeb (pad_oeb)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int op;
    logic [7:0] addrs [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h02, 8'hFC};

    // Reference model: lock as 0/1/2 with the cycle it armed, guard as a mask plus last guarded cycle.
    logic [NPADS-1:0] m_sel, m_mask;
    int               m_lock, m_arm, m_gend;

    task automatic reset_model();
        m_sel  = '0;
        m_mask = '0;
        m_lock = 0;
        m_arm  = -1000;
        m_gend = -1000;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic int lock_at(input int c);
        if (m_lock == 1 && (c - m_arm) > KEY_TIMEOUT) return 0;
        return m_lock;
    endfunction

    function automatic bit exp_err(input bit wr, input logic [7:0] addr, input logic [2:0] size, input int c);
        bit mapped;
        mapped = (addr == 8'h00) || (addr == 8'h04) || (addr == 8'h08) || (addr == 8'h0C);
        if (wr && addr == 8'h0C) return 1'b0;
        if (!mapped || size != 3'd2) return 1'b1;
        if (wr && addr == 8'h08) return 1'b1;
        if (wr && lock_at(c) != 2) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] addr, input int c);
        case (addr)
            8'h00:   return m_sel[31:0];
            8'h04:   return 32'(m_sel >> 32);
            8'h08:   return {29'd0, c <= m_gend, 2'(lock_at(c))};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input int d);
        logic [NPADS-1:0] nw, ch;
        if (addr == 8'h0C) begin
            case (lock_at(d))
                0: begin
                    if (data == K1) begin
                        m_lock = 1;
                        m_arm  = d;
                    end else m_lock = 0;
                end
                1:       m_lock = (data == K2) ? 2 : 0;
                default: m_lock = 0;
            endcase
        end else begin
            nw = m_sel;
            if (addr == 8'h00) nw[31:0] = data;
            else               nw[NPADS-1:32] = data[NPADS-33:0];
            ch = nw ^ m_sel;
            if (ch != '0) begin
                m_mask = ((m_gend > d) ? m_mask : '0) | ch;
                m_gend = d + GUARD;
            end
            m_sel = nw;
        end
    endtask

    // One AHB transfer; returns during the data phase so the next call pipelines behind it.
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input string tag);
        bit e;
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        bus.HSIZE  = size;
        tick();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wdata;
        #1;
        e = exp_err(wr, addr, size, cyc);
        if (e) begin
            chk({tag, " err1 hreadyout"}, 64'(bus.HREADYOUT), 64'd0);
            chk({tag, " err1 hresp"}, 64'(bus.HRESP), 64'd1);
            tick();
            #1;
            chk({tag, " err2 hreadyout"}, 64'(bus.HREADYOUT), 64'd1);
            chk({tag, " err2 hresp"}, 64'(bus.HRESP), 64'd1);
        end else begin
            chk({tag, " hreadyout"}, 64'(bus.HREADYOUT), 64'd1);
            chk({tag, " hresp"}, 64'(bus.HRESP), 64'd0);
            if (!wr) chk({tag, " hrdata"}, 64'(bus.HRDATA), 64'(exp_read(addr, cyc)));
            else     model_write(addr, wdata, cyc);
        end
    endtask

    task automatic check_pads(input string tag);
        logic [NPADS-1:0] g;
        alt0_out = NPADS'({$urandom(), $urandom()});
        alt0_oeb = NPADS'({$urandom(), $urandom()});
        alt1_out = NPADS'({$urandom(), $urandom()});
        alt1_oeb = NPADS'({$urandom(), $urandom()});
        pad_in   = NPADS'({$urandom(), $urandom()});
        #1;
        g = (cyc <= m_gend) ? m_mask : '0;
        chk({tag, " pad_out"}, 64'(pad_out), 64'(~g & ((m_sel & alt1_out) | (~m_sel & alt0_out))));
        chk({tag, " pad_oeb"}, 64'(pad_oeb), 64'(g | (m_sel & alt1_oeb) | (~m_sel & alt0_oeb)));
        chk({tag, " alt1_in"}, 64'(alt1_in), 64'(pad_in & m_sel));
        chk({tag, " alt0_in"}, 64'(alt0_in), 64'(pad_in & ~m_sel));
    endtask

    initial begin
        HRESETn    = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 8'h00;
        bus.HSIZE  = 3'd2;
        bus.HWDATA = 32'd0;
        alt0_out = '0; alt0_oeb = '0; alt1_out = '0; alt1_oeb = '0; pad_in = '0;
        reset_model();

        tick();
        chk("rst hreadyout", 64'(bus.HREADYOUT), 64'd1);
        chk("rst hresp", 64'(bus.HRESP), 64'd0);
        chk("rst hrdata", 64'(bus.HRDATA), 64'd0);
        check_pads("rst");
        tick();
        HRESETn = 1'b1;
        tick();

        // SEL write while locked
        xfer(1'b1, 8'h00, 3'd2, 32'h1, "locked sel wr");
        idle(1);
        check_pads("locked pads");
        xfer(1'b0, 8'h00, 3'd2, 32'h0, "locked sel rd");

        // unlock, second key three cycles after the first
        xfer(1'b1, 8'h0C, 3'd2, K1, "key1");
        idle(2);
        xfer(1'b1, 8'h0C, 3'd2, K2, "key2");
        xfer(1'b0, 8'h08, 3'd2, 32'h0, "status unlocked");

        // guard window on pads 0 and 14
        xfer(1'b1, 8'h00, 3'd2, 32'h0000_4001, "sel lo wr");
        for (int k = 1; k <= GUARD + 2; k++) begin
            tick();
            check_pads($sformatf("guard c%0d", k));
        end
        xfer(1'b0, 8'h00, 3'd2, 32'h0, "sel lo rd");
        xfer(1'b1, 8'h00, 3'd2, 32'h0, "sel lo clr");
        xfer(1'b0, 8'h08, 3'd2, 32'h0, "status guard");
        idle(GUARD + 1);
        xfer(1'b0, 8'h08, 3'd2, 32'h0, "status no guard");

        // pad 37 via SEL_HI, back-to-back with a SEL_LO read
        xfer(1'b1, 8'h04, 3'd2, 32'h20, "sel hi wr");
        xfer(1'b0, 8'h00, 3'd2, 32'h0, "b2b sel lo rd");
        tick();
        check_pads("pad37");
        xfer(1'b0, 8'h04, 3'd2, 32'h0, "sel hi rd");
        idle(GUARD + 1);

        // relock paths
        xfer(1'b1, 8'h0C, 3'd2, 32'h0, "key relock");
        xfer(1'b0, 8'h08, 3'd2, 32'h0, "status relocked");
        xfer(1'b1, 8'h0C, 3'd2, K1, "key1 b");
        xfer(1'b1, 8'h0C, 3'd2, 32'h1234, "key bad");
        xfer(1'b0, 8'h08, 3'd2, 32'h0, "status after bad key");

        // key timeout, and second key on the last armed cycle
        xfer(1'b1, 8'h0C, 3'd2, K1, "key1 c");
        idle(KEY_TIMEOUT);
        xfer(1'b0, 8'h08, 3'd2, 32'h0, "status timed out");
        xfer(1'b1, 8'h0C, 3'd2, K2, "key2 late");
        xfer(1'b0, 8'h08, 3'd2, 32'h0, "status still locked");
        xfer(1'b1, 8'h0C, 3'd2, K1, "key1 d");
        idle(KEY_TIMEOUT - 1);
        xfer(1'b1, 8'h0C, 3'd2, K2, "key2 last cycle");
        xfer(1'b0, 8'h08, 3'd2, 32'h0, "status edge unlocked");

        // error responses
        xfer(1'b0, 8'h10, 3'd2, 32'h0, "unmapped rd");
        xfer(1'b1, 8'h00, 3'd0, 32'hFFFF_FFFF, "byte wr");
        xfer(1'b0, 8'h00, 3'd2, 32'h0, "sel lo after byte");
        xfer(1'b1, 8'h08, 3'd2, 32'h7, "status wr");
        xfer(1'b0, 8'h0C, 3'd2, 32'h0, "key rd");
        idle(1);
        check_pads("after errors");

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 10));
            case (op)
                0, 1:    xfer(1'b1, 8'h0C, 3'd2, K1, "rnd key1");
                2, 3:    xfer(1'b1, 8'h0C, 3'd2, K2, "rnd key2");
                4:       xfer(1'b1, 8'h0C, 3'd2, $urandom(), "rnd key");
                5:       xfer(1'b1, 8'h00, 3'd2, $urandom(), "rnd sel lo");
                6:       xfer(1'b1, 8'h04, 3'd2, $urandom(), "rnd sel hi");
                7:       xfer(1'b0, addrs[$urandom_range(0, 6)],
                              ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd2, 32'h0, "rnd rd");
                8:       xfer(1'b1, addrs[$urandom_range(0, 2)],
                              ($urandom_range(0, 2) == 0) ? 3'd0 : 3'd2, $urandom(), "rnd wr");
                default: begin
                    idle(int'($urandom_range(1, 18)));
                    check_pads("rnd pads");
                end
            endcase
        end

        // reset in the middle of a guard window
        idle(1);
        xfer(1'b1, 8'h0C, 3'd2, 32'h0, "pre rst lock");
        xfer(1'b1, 8'h0C, 3'd2, K1, "pre rst key1");
        xfer(1'b1, 8'h0C, 3'd2, K2, "pre rst key2");
        xfer(1'b1, 8'h00, 3'd2, ~m_sel[31:0], "pre rst sel");
        tick();
        HRESETn = 1'b0;
        #1;
        reset_model();
        chk("midrst hreadyout", 64'(bus.HREADYOUT), 64'd1);
        chk("midrst hresp", 64'(bus.HRESP), 64'd0);
        chk("midrst hrdata", 64'(bus.HRDATA), 64'd0);
        check_pads("midrst");
        tick();
        HRESETn = 1'b1;
        tick();
        xfer(1'b0, 8'h00, 3'd2, 32'h0, "post rst sel");
        xfer(1'b0, 8'h08, 3'd2, 32'h0, "post rst status");
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_pinmux_ctrl.md
# io_pinmux_ctrl

AHB-Lite-configured pad function multiplexer for the 38 Caravel user I/O pads of the N5 SoC. Each pad is owned by one of two sources (alt0 = fixed peripheral function, alt1 = secondary function, e.g. GPIO). The block sits between `soc_core` and the wrapper's `io_in`/`io_out`/`io_oeb`. Reconfiguration is protected by a two-write unlock key sequence. Any pad whose owner changes is held tri-stated for a guard interval.

## Interface
- `NPADS`, 38: number of pads, 33..64.
- `GUARD`, 4: tri-state guard cycles after an ownership change, 1..15.
- `KEY_TIMEOUT`, 16: maximum cycles between the first and second key writes, 2..255.

Ports:
- `HCLK` in 1: sole clock.
- `HRESETn` in 1: asynchronous, active-low reset.
- `HSEL` in 1, `HTRANS` in 2, `HWRITE` in 1, `HSIZE` in 3, `HADDR` in 8, `HREADY` in 1, `HWDATA` in 32: AHB-Lite slave inputs.
- `HRDATA` out 32, `HREADYOUT` out 1, `HRESP` out 1: AHB-Lite slave outputs.
- `alt0_out`, `alt0_oeb` in NPADS: alt0 source drive and output-enable (oeb=1 means input).
- `alt1_out`, `alt1_oeb` in NPADS: alt1 source drive and output-enable.
- `alt0_in`, `alt1_in` out NPADS: pad input routed to the owning source.
- `pad_in` in NPADS: pad inputs.
- `pad_out`, `pad_oeb` out NPADS: pad outputs.

## Operation
- Registers (word-addressed, `HADDR[7:0]`):
  - 0x00 SEL_LO: pads 31:0.
  - 0x04 SEL_HI: pads NPADS-1:32. Unused bits read 0.
  - 0x08 STATUS, read-only:
    - [1:0] lock state: 0 LOCKED, 1 ARMED, 2 UNLOCKED.
    - [2] guard active.
  - 0x0C KEY, write-only; reads return 0.
- SEL bit = 1 gives pad ownership to alt1; 0 gives it to alt0. Reset value is all 0.
- Pad path, combinational:
  - If `guard_mask[i]` is set: `pad_out[i]`=0, `pad_oeb[i]`=1.
  - Otherwise: `pad_out`/`pad_oeb` come from the owning source.
- Input path: `alt*_in[i]` = `pad_in[i]` for the owning source and 0 for the other. The guard does not affect the input path.
- Lock FSM. Reset state is LOCKED.
  - LOCKED: KEY write 0x5A5A_0001 → ARMED and load timer = KEY_TIMEOUT. Any other KEY write stays in LOCKED.
  - ARMED:
    - KEY write 0xA5A5_0002 → UNLOCKED.
    - Any other KEY write → LOCKED.
    - Timer decrements every cycle; reaching 0 → LOCKED.
  - UNLOCKED: any KEY write → LOCKED. SEL writes do not relock.
- SEL write accepted only in UNLOCKED:
  - `changed = old ^ new`.
  - `guard_mask |= changed`.
  - Guard counter reloads to GUARD.
  - New SEL takes effect the same cycle the mask is set.
- Guard counter decrements each cycle while nonzero. Going 1→0 clears the entire `guard_mask`.
- A SEL write that changes no bits does not reload the counter.
- Error response (two-cycle AHB ERROR) is returned for:
  - a SEL write while not UNLOCKED;
  - any unmapped address;
  - HSIZE ≠ 2;
  - a write to STATUS.
- An errored write changes no state. KEY writes never error.

## Timing
- Address phase is captured when `HSEL & HREADY & HTRANS[1]`. IDLE/BUSY transfers get OKAY with zero wait states.
- Write data is taken in the data phase. Register, FSM and guard updates are visible on the next HCLK edge.
- Reads: `HRDATA` is driven combinationally in the data phase from the captured address. Zero wait states.
- Error sequence:
  - Cycle 1: `HREADYOUT`=0, `HRESP`=1.
  - Cycle 2: `HREADYOUT`=1, `HRESP`=1.
  - Then back to OKAY.
- Back-to-back pipelined transfers are supported. A read of SEL immediately after a SEL write returns the new value.
- Simultaneous events:
  - A SEL write in the cycle the guard expires: the new mask is `changed` only, and the counter reloads.
  - A second-key write in the cycle the timer reaches 0: the write wins → UNLOCKED.
- Reset values of outputs:
  - `HRDATA`=0, `HREADYOUT`=1, `HRESP`=0.
  - `guard_mask`=0 and SEL=0, so the pad pins follow alt0.
- Reset asserted mid-error or mid-guard aborts immediately to the reset state.

## Test plan
- Reset, then SEL write 0x1 while LOCKED → two-cycle ERROR; SEL_LO still reads 0; pad 0 follows alt0.
- Key writes 0x5A5A_0001, then 0xA5A5_0002 three cycles later → STATUS[1:0]=2. SEL_LO write 0x0000_4001 → pads 0 and 14 have `pad_oeb`=1 for exactly 4 cycles, then follow alt1. STATUS[2]=1 during the guard.
- First key write, then 16 idle cycles → STATUS reads 0. The second key write then leaves the FSM in LOCKED.
- In ARMED, KEY write 0x1234 → LOCKED. In UNLOCKED, a KEY write → LOCKED.
- In UNLOCKED, SEL_HI write 0x20 (pad 37) followed by a SEL_LO read, back-to-back → OKAY, zero waits. Only pad 37 is guarded. `alt1_in[37]` = `pad_in[37]` and `alt0_in[37]`=0.
- Read of address 0x10 → ERROR. Byte write (HSIZE=0) to SEL_LO → ERROR, no change. Assert HRESETn low during a guard → all outputs return to their reset values.
